// File: rtl/commit_trace_arbiter_pkg.sv
// Shared types for the commit trace path.
// Holds the trace record layout, sequence width and a record builder.
package commit_trace_arbiter_pkg;

    localparam int unsigned TRACE_SEQ_W = 16;

    typedef enum logic [1:0] {
        PRIV_U = 2'b00,
        PRIV_S = 2'b01,
        PRIV_M = 2'b11
    } priv_lvl_t;

    typedef struct packed {
        logic [TRACE_SEQ_W-1:0] seq;
        logic [63:0]            pc;
        logic [31:0]            instr;
        logic [4:0]             waddr;
        logic [63:0]            wdata;
        logic                   we_gpr;
        logic                   we_fpr;
        logic                   we_posr;
        priv_lvl_t              priv_lvl;
    } trace_rec_t;

    function automatic trace_rec_t make_rec(
        input logic [TRACE_SEQ_W-1:0] seq,
        input logic [63:0]            pc,
        input logic [31:0]            instr,
        input logic [4:0]             waddr,
        input logic [63:0]            wdata,
        input logic                   we_gpr,
        input logic                   we_fpr,
        input logic                   we_posr,
        input priv_lvl_t              priv_lvl
    );
        trace_rec_t r;
        r.seq      = seq;
        r.pc       = pc;
        r.instr    = instr;
        r.waddr    = waddr;
        r.wdata    = wdata;
        r.we_gpr   = we_gpr;
        r.we_fpr   = we_fpr;
        r.we_posr  = we_posr;
        r.priv_lvl = priv_lvl;
        return r;
    endfunction

endpackage

// File: rtl/commit_trace_arbiter_fifo.sv
// Trace record FIFO with two in-order write ports and one read port.
// Ports: we0/we1 + data (we1 honoured only with we0), pop, head valid/data, count.
module trace_fifo_2w1r
    import commit_trace_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     we0_i,
    input  logic                     we1_i,
    input  trace_rec_t               wdata0_i,
    input  trace_rec_t               wdata1_i,
    input  logic                     pop_i,
    output logic                     valid_o,
    output trace_rec_t               rdata_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    trace_rec_t      mem [DEPTH];
    logic [AW-1:0]   wptr_q;
    logic [AW-1:0]   rptr_q;
    logic [CW-1:0]   count_q;
    logic [AW-1:0]   wptr1;
    logic [1:0]      n_push;

    assign wptr1  = wptr_q + AW'(1);
    assign n_push = we0_i ? (we1_i ? 2'd2 : 2'd1) : 2'd0;

    always_ff @(posedge clk_i) begin
        if (we0_i) mem[wptr_q] <= wdata0_i;
        if (we0_i && we1_i) mem[wptr1] <= wdata1_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_q + AW'(n_push);
            rptr_q  <= rptr_q + AW'(pop_i);
            count_q <= count_q + CW'(n_push) - CW'(pop_i);
        end
    end

    // Head is forced to zero when empty so stale storage never leaks out.
    assign valid_o = (count_q != '0);
    assign rdata_o = valid_o ? mem[rptr_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/commit_trace_arbiter.sv
// Serialises up to two commit records per cycle into an in-order trace stream.
// Ports: commit taps in, valid/ready trace out, occupancy, drop count, overflow.
module commit_trace_arbiter
    import commit_trace_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH        = 8,
    parameter bit          FILTER_DEBUG = 1'b1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      trace_en_i,
    input  logic                      clear_i,
    input  logic [1:0]                commit_ack_i,
    input  logic [1:0][63:0]          commit_pc_i,
    input  logic [1:0][31:0]          commit_instr_i,
    input  logic [1:0][4:0]           waddr_i,
    input  logic [1:0][63:0]          wdata_i,
    input  logic [1:0]                we_gpr_i,
    input  logic [1:0]                we_fpr_i,
    input  logic [1:0]                we_posr_i,
    input  priv_lvl_t                 priv_lvl_i,
    input  logic                      debug_mode_i,
    output logic                      trace_valid_o,
    input  logic                      trace_ready_i,
    output trace_rec_t                trace_rec_o,
    output logic [$clog2(DEPTH):0]    count_o,
    output logic [15:0]               drop_cnt_o,
    output logic                      overflow_o
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic                   en;
    logic                   pop;
    logic                   first;
    logic [1:0]             n_cand;
    logic [1:0]             n_acc;
    logic [1:0]             n_drop;
    logic [CW-1:0]          free;
    logic [TRACE_SEQ_W-1:0] seq_q;
    logic [15:0]            drop_q;
    logic [15:0]            drop_base;
    logic [16:0]            drop_sum;
    logic                   ovf_q;
    trace_rec_t             rec0;
    trace_rec_t             rec1;

    assign pop   = trace_valid_o & trace_ready_i;
    assign en    = trace_en_i & ~(FILTER_DEBUG & debug_mode_i);
    assign first = ~commit_ack_i[0];

    assign n_cand = en ? ({1'b0, commit_ack_i[0]} + {1'b0, commit_ack_i[1]})
                       : 2'd0;

    // A pop this cycle frees a slot for a same-cycle push.
    assign free = CW'(DEPTH) - count_o + CW'(pop);

    always_comb begin
        n_acc = 2'd0;
        if (n_cand == 2'd2 && free >= CW'(2)) n_acc = 2'd2;
        else if (n_cand != 2'd0 && free != '0) n_acc = 2'd1;
    end

    assign n_drop = n_cand - n_acc;

    // Port 1 alone is compacted into the first slot.
    assign rec0 = make_rec(seq_q,
                           commit_pc_i[first], commit_instr_i[first],
                           waddr_i[first], wdata_i[first],
                           we_gpr_i[first], we_fpr_i[first],
                           we_posr_i[first], priv_lvl_i);

    assign rec1 = make_rec(seq_q + TRACE_SEQ_W'(1),
                           commit_pc_i[1], commit_instr_i[1],
                           waddr_i[1], wdata_i[1],
                           we_gpr_i[1], we_fpr_i[1],
                           we_posr_i[1], priv_lvl_i);

    // Clear applies first so same-cycle drops survive it.
    assign drop_base = clear_i ? 16'd0 : drop_q;
    assign drop_sum  = {1'b0, drop_base} + 17'(n_drop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            seq_q  <= '0;
            drop_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            seq_q  <= seq_q + TRACE_SEQ_W'(n_cand);
            drop_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            ovf_q  <= (ovf_q & ~clear_i) | (n_drop != 2'd0);
        end
    end

    assign drop_cnt_o = drop_q;
    assign overflow_o = ovf_q;

    trace_fifo_2w1r #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .we0_i    (n_acc != 2'd0),
        .we1_i    (n_acc == 2'd2),
        .wdata0_i (rec0),
        .wdata1_i (rec1),
        .pop_i    (pop),
        .valid_o  (trace_valid_o),
        .rdata_o  (trace_rec_o),
        .count_o  (count_o)
    );

endmodule
